alu: RTL and testbench



---
 rtl/alu.sv | 161 ++++++++++++++++
 tb/tb_alu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- parameterised integer ALU for the datapath.
//
// Operations (operands unsigned, arithmetic modulo 2^WIDTH):
//   000 add, 001 subtract, 010 low-half multiply, 011 unsigned divide,
//   100 load-address add, 101 store-address add, 110/111 return zero.
//
// Single-cycle operations write result on the accepting edge and pulse
// out_valid for the following cycle. DIV is a restoring divider that takes
// WIDTH cycles; busy is high while it runs and requests arriving during that
// time are dropped. A divide by zero yields all ones.
//
// Optional build macro: ALU_FLAGS_EN adds registered zero_flag and neg_flag
// outputs that track the value written into result.
// -----------------------------------------------------------------------------
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             busy
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero_flag,
    output logic             neg_flag
`endif
);

    // Step counter must hold values up to WIDTH-1.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_LDA  = 3'b100;
    localparam logic [2:0] OP_STA  = 3'b101;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_DIVIDE = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    step_q;

    logic             accept;
    logic             start_div;
    logic             last_step;
    logic [WIDTH-1:0] alu_value;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dvd_next;
    logic             result_load;
    logic [WIDTH-1:0] result_next;

    assign busy      = (state == ST_DIVIDE);
    assign accept    = in_valid && (state == ST_IDLE);
    assign start_div = accept && (opcode == OP_DIV);
    assign last_step = (step_q == CW'(WIDTH - 1));

    // Single-cycle datapath: operands straight from the register file ports.
    always_comb begin
        alu_value = '0;
        case (opcode)
            OP_ADD:  alu_value = a + b;
            OP_SUB:  alu_value = a - b;
            OP_MUL:  alu_value = a * b;
            OP_LDA:  alu_value = a + b;
            OP_STA:  alu_value = a + b;
            default: alu_value = '0;
        endcase
    end

    // One restoring step: shift in the next dividend bit and try a subtract.
    // The subtract borrow (top bit) tells whether the divisor fitted, and
    // the quotient bit is shifted into the vacated dividend LSB.
    always_comb begin
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        q_bit     = ~rem_diff[WIDTH];
        rem_next  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        dvd_next  = {dvd_q[WIDTH-2:0], q_bit};
    end

    // Select what, if anything, is written into result on this edge.
    always_comb begin
        result_load = 1'b0;
        result_next = result;
        if ((state == ST_DIVIDE) && last_step) begin
            result_load = 1'b1;
            result_next = dvd_next;
        end else if (accept && (opcode != OP_DIV)) begin
            result_load = 1'b1;
            result_next = alu_value;
        end
    end

    // Divider sequencer: latch operands on acceptance, then WIDTH steps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            step_q <= '0;
        end else if (state == ST_IDLE) begin
            if (start_div) begin
                dvd_q  <= a;
                dvs_q  <= b;
                rem_q  <= '0;
                step_q <= '0;
                state  <= ST_DIVIDE;
            end
        end else begin
            dvd_q  <= dvd_next;
            rem_q  <= rem_next;
            step_q <= step_q + CW'(1);
            if (last_step) begin
                state <= ST_IDLE;
            end
        end
    end

    // Result register and the one-cycle completion pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= result_load;
            if (result_load) begin
                result <= result_next;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    // Status flags follow the value loaded into result on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
        end else if (result_load) begin
            zero_flag <= (result_next == '0);
            neg_flag  <= result_next[WIDTH-1];
        end
    end
`else
`endif

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu (WIDTH = 16).
// A cycle-level reference model tracks the expected result, out_valid and
// busy from the operation rules and the divide latency; directed sequences
// are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_alu;

    localparam int WIDTH = 16;
    localparam longint unsigned MASK = (64'd1 << WIDTH) - 64'd1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             busy;
`ifdef ALU_FLAGS_EN
    logic             zero_flag;
    logic             neg_flag;
`endif

    int checks   = 0;
    int failures = 0;

    longint unsigned m_result = 0;
    longint unsigned m_quot   = 0;
    bit              m_ov     = 1'b0;
    bit              m_busy   = 1'b0;
    int              m_left   = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .result    (result),
        .out_valid (out_valid),
        .busy      (busy)
`ifdef ALU_FLAGS_EN
        ,
        .zero_flag (zero_flag),
        .neg_flag  (neg_flag)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Arithmetic reference: plain integer maths reduced modulo 2^WIDTH.
    function automatic longint unsigned refOp(input int op, input longint unsigned x,
                                              input longint unsigned y);
        case (op)
            0, 4, 5: return (x + y) & MASK;
            1:       return (x - y) & MASK;
            2:       return (x * y) & MASK;
            3:       return (y == 0) ? MASK : (x / y);
            default: return 0;
        endcase
    endfunction

    // Model of one clock edge: single-cycle ops complete immediately, a divide
    // completes WIDTH edges after acceptance and blocks requests meanwhile.
    task automatic modelEdge(input bit r, input bit v, input int op,
                             input longint unsigned x, input longint unsigned y);
        if (!r) begin
            m_result = 0;
            m_ov     = 1'b0;
            m_left   = 0;
        end else begin
            m_ov = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_result = m_quot;
                    m_ov     = 1'b1;
                end
            end else if (v) begin
                if (op == 3) begin
                    m_left = WIDTH;
                    m_quot = refOp(3, x, y);
                end else begin
                    m_result = refOp(op, x, y);
                    m_ov     = 1'b1;
                end
            end
        end
        m_busy = (m_left > 0);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge and compare all outputs.
    task automatic applyStimulus(input string tag, input bit r, input bit v, input int op,
                                 input longint unsigned x, input longint unsigned y);
        rst_n    = r;
        in_valid = v;
        opcode   = op[2:0];
        a        = x[WIDTH-1:0];
        b        = y[WIDTH-1:0];
        @(posedge clk);
        modelEdge(r, v, op, x, y);
        #1;
        checkOutput({tag, ".result"}, 64'(result), m_result);
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
        checkOutput({tag, ".busy"}, 64'(busy), 64'(m_busy));
`ifdef ALU_FLAGS_EN
        checkOutput({tag, ".zero_flag"}, 64'(zero_flag), 64'(m_result == 0));
        checkOutput({tag, ".neg_flag"}, 64'(neg_flag), 64'(m_result[WIDTH-1]));
`endif
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(tag, 1'b1, 1'b0, 0, 0, 0);
        end
    endtask

    initial begin
        longint unsigned x;
        longint unsigned y;
        int              op;
        bit              v;
        bit              r;

        // Reset held with a request pending.
        applyStimulus("reset0", 1'b0, 1'b1, 0, 5, 5);
        applyStimulus("reset1", 1'b0, 1'b1, 0, 5, 5);
        checkOutput("reset.result_zero", 64'(result), 64'd0);

        // Back-to-back add / load-address / store-address.
        applyStimulus("add", 1'b1, 1'b1, 0, 28, 22);
        checkOutput("add_28_22", 64'(result), 64'd50);
        applyStimulus("lda", 1'b1, 1'b1, 4, 10, 32);
        checkOutput("lda_10_32", 64'(result), 64'd42);
        applyStimulus("sta", 1'b1, 1'b1, 5, 2, 40);
        checkOutput("sta_2_40", 64'(result), 64'd42);
        checkOutput("sta_pulse", 64'(out_valid), 64'd1);
        idle("hold", 2);
        checkOutput("hold_result", 64'(result), 64'd42);
        checkOutput("hold_no_pulse", 64'(out_valid), 64'd0);

        // Subtract, including wrap below zero.
        applyStimulus("sub", 1'b1, 1'b1, 1, 100, 58);
        checkOutput("sub_100_58", 64'(result), 64'd42);
        applyStimulus("subw", 1'b1, 1'b1, 1, 6, 8);
        checkOutput("sub_wrap", 64'(result), 64'hFFFE);

        // Multiply, low half only.
        applyStimulus("mul", 1'b1, 1'b1, 2, 3, 4);
        checkOutput("mul_3_4", 64'(result), 64'd12);
        applyStimulus("mul", 1'b1, 1'b1, 2, 6, 7);
        checkOutput("mul_6_7", 64'(result), 64'd42);
        applyStimulus("mul", 1'b1, 1'b1, 2, 300, 200);
        checkOutput("mul_300_200", 64'(result), 64'd60000);
        applyStimulus("mul", 1'b1, 1'b1, 2, 0, 123);
        checkOutput("mul_0_123", 64'(result), 64'd0);
        applyStimulus("mul", 1'b1, 1'b1, 2, 16'hFFFF, 2);
        checkOutput("mul_trunc", 64'(result), 64'hFFFE);

        // Reserved opcodes give zero.
        applyStimulus("op6", 1'b1, 1'b1, 6, 9, 9);
        applyStimulus("op7", 1'b1, 1'b1, 7, 9, 9);
        checkOutput("op7_zero", 64'(result), 64'd0);

        // Divide 10/3 with an ADD attempted mid-divide (must be dropped).
        applyStimulus("div_start", 1'b1, 1'b1, 3, 10, 3);
        for (int i = 1; i <= WIDTH; i++) begin
            applyStimulus("div_run", 1'b1, (i == 5), 0, 1, 1);
            if (i < WIDTH) begin
                checkOutput("div_busy_high", 64'(busy), 64'd1);
            end
        end
        checkOutput("div_10_3", 64'(result), 64'd3);
        checkOutput("div_10_3_pulse", 64'(out_valid), 64'd1);
        checkOutput("div_10_3_busy_low", 64'(busy), 64'd0);

        // Divide 1000/5 issued on the earliest accepting edge.
        applyStimulus("div_start", 1'b1, 1'b1, 3, 1000, 5);
        idle("div_run", WIDTH);
        checkOutput("div_1000_5", 64'(result), 64'd200);
        checkOutput("div_1000_5_pulse", 64'(out_valid), 64'd1);

        // Divide by zero.
        applyStimulus("div0_start", 1'b1, 1'b1, 3, 7, 0);
        idle("div0_run", WIDTH);
        checkOutput("div_7_0", 64'(result), 64'hFFFF);

        // Reset during a divide aborts it without a completion pulse.
        applyStimulus("rdiv_start", 1'b1, 1'b1, 3, 1000, 5);
        idle("rdiv_run", 4);
        applyStimulus("rdiv_reset", 1'b0, 1'b0, 0, 0, 0);
        checkOutput("rdiv_busy", 64'(busy), 64'd0);
        checkOutput("rdiv_result", 64'(result), 64'd0);
        checkOutput("rdiv_pulse", 64'(out_valid), 64'd0);
        idle("rdiv_after", WIDTH + 4);
        applyStimulus("rdiv_add", 1'b1, 1'b1, 0, 20, 22);
        checkOutput("rdiv_add_42", 64'(result), 64'd42);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = int'($urandom_range(0, 7));
            r  = ($urandom_range(0, 63) != 0);
            x  = longint'($urandom) & MASK;
            case ($urandom_range(0, 7))
                0:       y = 0;
                1, 2:    y = longint'($urandom_range(1, 15));
                default: y = longint'($urandom) & MASK;
            endcase
            applyStimulus("rand", r, v, op, x, y);
        end
        idle("drain", WIDTH + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
